// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter (CPU read/write, display read-only) in front of a single
//   synchronous-read RAM. Each access takes a fixed four-cycle walk through
//   IDLE -> ISSUE -> CAPTURE -> ACK, so at most one access is in flight.
//
//   Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on
//   contention (the requester not granted last wins). Without it the CPU
//   always wins contention.
//
//   Ports
//     clk, reset               system clock, synchronous active-high reset
//     cpu_req/we/addr/wdata    CPU request, held stable until cpu_ready
//     cpu_ready, cpu_rdata     one-cycle completion pulse and read data
//     disp_req, disp_addr      display read request, held until disp_ready
//     disp_ready, disp_rdata   one-cycle completion pulse and read data
//     mem_en/we/addr/wdata     registered RAM control
//     mem_rdata                RAM read data, valid the cycle after mem_en
//     busy                     high whenever an access is in flight
//
//   States
//     IDLE    | waiting for a request; winner latched onto mem_* on accept
//     ISSUE   | mem_en (and mem_we for writes) high for this single cycle
//     CAPTURE | RAM output valid; captured into owner's rdata on exit
//     ACK     | owner's ready high; requests sampled here are ignored
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ready,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic grant_cpu;
    logic owner_cpu;
    logic owner_we;

    assign accept = (state == IDLE) && (cpu_req || disp_req);
    assign busy   = (state != IDLE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 when the display held the most recent grant; reset favours the CPU.
    logic last_disp;

    always_comb begin
        grant_cpu = cpu_req;
        if (cpu_req && disp_req) begin
            grant_cpu = last_disp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_disp <= 1'b1;
        end else if (accept) begin
            last_disp <= !grant_cpu;
        end
    end
`else
    always_comb begin
        grant_cpu = cpu_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cpu_req || disp_req) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready pulses and RAM strobes default low every cycle, so each is high
    // for exactly the one cycle following the edge that sets it.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ready  <= 1'b0;
            disp_ready <= 1'b0;
            cpu_rdata  <= '0;
            disp_rdata <= '0;
            owner_cpu  <= 1'b0;
            owner_we   <= 1'b0;
        end else begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            cpu_ready  <= 1'b0;
            disp_ready <= 1'b0;

            if (accept) begin
                owner_cpu <= grant_cpu;
                owner_we  <= grant_cpu && cpu_we;
                mem_en    <= 1'b1;
                mem_we    <= grant_cpu && cpu_we;
                mem_addr  <= grant_cpu ? cpu_addr : disp_addr;
                if (grant_cpu) begin
                    mem_wdata <= cpu_wdata;
                end
            end

            if (state == CAPTURE) begin
                if (owner_cpu) begin
                    cpu_ready <= 1'b1;
                    // Writes leave the last read value visible to the CPU.
                    if (!owner_we) begin
                        cpu_rdata <= mem_rdata;
                    end
                end else begin
                    disp_ready <= 1'b1;
                    disp_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter: directed scenarios followed by random traffic from
//   two requester agents. A transaction-level timeline model predicts, per
//   cycle, which ready pulses, RAM strobes and rdata values must be visible.
module tb_mem_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ready;
    logic [DATA_W-1:0] disp_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_ready (disp_ready),
        .disp_rdata (disp_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Power-up RAM contents; 0x200 holds 0xA2.
    function automatic logic [7:0] init_val(input logic [11:0] a);
        if (a == 12'h200) return 8'hA2;
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
    endfunction

    // Synchronous-read RAM
    logic [7:0] ram_mem [4096];
    bit         ram_vld [4096];
    logic [7:0] ram_q;
    assign mem_rdata = ram_q;

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            ram_q <= ram_vld[mem_addr] ? ram_mem[mem_addr] : init_val(mem_addr);
            if (mem_we === 1'b1) begin
                ram_mem[mem_addr] <= mem_wdata;
                ram_vld[mem_addr] <= 1'b1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: one transaction occupies edges start..start+3; the
    // next may begin at start+4. Ready is visible after edge start+2.
    logic [7:0]  mdl_mem [logic [11:0]];
    int          k       = 0;
    int          m_start = -100;
    int          m_next  = 0;
    bit          m_own_cpu;
    bit          m_we;
    logic [11:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_data;
    logic [7:0]  e_cpu_rd  = '0;
    logic [7:0]  e_disp_rd = '0;
    int          n_cpu_rdy  = 0;
    int          n_disp_rdy = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    bit          m_last_cpu = 1'b0;
`endif

    function automatic logic [7:0] mdl_read(input logic [11:0] a);
        if (mdl_mem.exists(a)) return mdl_mem[a];
        return init_val(a);
    endfunction

    task automatic cycle();
        bit win;
        bit e_en, e_busy, e_crdy, e_drdy;
        @(posedge clk);
        #1;
        k++;
        if (reset) begin
            m_start   = -100;
            m_next    = k + 1;
            e_cpu_rd  = '0;
            e_disp_rd = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            m_last_cpu = 1'b0;
`endif
        end else begin
            if (k >= m_next && (cpu_req || disp_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (cpu_req && disp_req) win = !m_last_cpu;
                else win = cpu_req;
                m_last_cpu = win;
`else
                win = cpu_req;
`endif
                m_start   = k;
                m_next    = k + 4;
                m_own_cpu = win;
                m_we      = win && cpu_we;
                m_addr    = win ? cpu_addr : disp_addr;
                m_wdata   = cpu_wdata;
                m_data    = mdl_read(m_addr);
                if (m_we) mdl_mem[m_addr] = cpu_wdata;
            end
            if (k == m_start + 2) begin
                if (m_own_cpu) begin
                    if (!m_we) e_cpu_rd = m_data;
                end else begin
                    e_disp_rd = m_data;
                end
            end
        end
        e_en   = (k == m_start);
        e_busy = (k >= m_start) && (k <= m_start + 2);
        e_crdy = (k == m_start + 2) && m_own_cpu;
        e_drdy = (k == m_start + 2) && !m_own_cpu;

        check_val("cpu_ready",  32'(cpu_ready),  32'(e_crdy));
        check_val("disp_ready", 32'(disp_ready), 32'(e_drdy));
        check_val("cpu_rdata",  32'(cpu_rdata),  32'(e_cpu_rd));
        check_val("disp_rdata", 32'(disp_rdata), 32'(e_disp_rd));
        check_val("mem_en",     32'(mem_en),     32'(e_en));
        check_val("mem_we",     32'(mem_we),     32'(e_en && m_we));
        check_val("busy",       32'(busy),       32'(e_busy));
        if (e_en) begin
            check_val("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_we) check_val("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        end
        if (cpu_ready === 1'b1)  n_cpu_rdy++;
        if (disp_ready === 1'b1) n_disp_rdy++;
    endtask

    // Present one request, wait for its ready, hold through ACK, drop at E3.
    task automatic serve(input bit is_cpu, input bit we, input logic [11:0] addr,
                         input logic [7:0] wdata, output int lat, output logic [7:0] rd);
        bit got;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        if (is_cpu) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            disp_req = 1'b1; disp_addr = addr;
        end
        while (!got && lat < 20) begin
            cycle();
            lat++;
            if (is_cpu ? cpu_ready : disp_ready) begin
                got = 1'b1;
                rd  = is_cpu ? cpu_rdata : disp_rdata;
            end
        end
        if (!got) check_val("serve_timeout", 32'd0, 32'd1);
        cycle();
        if (is_cpu) cpu_req = 1'b0;
        else disp_req = 1'b0;
    endtask

    task automatic new_cpu();
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(1, 0));
        cpu_addr  = 12'h100 | 12'($urandom_range(15, 0));
        cpu_wdata = 8'($urandom);
    endtask

    task automatic new_disp();
        disp_req  = 1'b1;
        disp_addr = 12'h100 | 12'($urandom_range(15, 0));
    endtask

    initial begin
        int         lat;
        logic [7:0] rd;
        int         c0, d0;
        int         grants[$];
        bit         got;
        bit         c_hold, d_hold;

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        disp_req = 1'b0; disp_addr = '0;
        cycle();
        cycle();
        check_val("rst_mem_addr",  32'(mem_addr),  32'd0);
        check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        reset = 1'b0;
        cycle();

        // CPU read of 0x200
        serve(1'b1, 1'b0, 12'h200, 8'h00, lat, rd);
        check_val("rd200_latency", 32'(lat), 32'd3);
        check_val("rd200_data",    32'(rd),  32'hA2);
        check_val("rd200_no_disp", 32'(n_disp_rdy), 32'd0);

        // CPU write then read back
        serve(1'b1, 1'b1, 12'h300, 8'h5C, lat, rd);
        check_val("wr300_latency", 32'(lat), 32'd3);
        check_val("wr300_rdata_held", 32'(cpu_rdata), 32'hA2);
        serve(1'b1, 1'b0, 12'h300, 8'h00, lat, rd);
        check_val("rd300_data", 32'(rd), 32'h5C);

        // Single-pulse per request when req is held through ACK
        c0 = n_cpu_rdy;
        serve(1'b1, 1'b0, 12'h123, 8'h00, lat, rd);
        repeat (6) cycle();
        check_val("cpu_one_pulse", 32'(n_cpu_rdy - c0), 32'd1);
        d0 = n_disp_rdy;
        serve(1'b0, 1'b0, 12'h200, 8'h00, lat, rd);
        repeat (6) cycle();
        check_val("disp_one_pulse", 32'(n_disp_rdy - d0), 32'd1);
        check_val("disp_rd200", 32'(rd), 32'hA2);

        // Contention, both requests held continuously
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
        disp_req = 1'b1; disp_addr = 12'h020;
        for (int i = 0; i < 60 && grants.size() < 8; i++) begin
            cycle();
            if (cpu_ready)  grants.push_back(1);
            if (disp_ready) grants.push_back(0);
        end
        cpu_req = 1'b0;
        disp_req = 1'b0;
        check_val("contend_count", 32'(grants.size()), 32'd8);
        foreach (grants[i]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            check_val($sformatf("contend_grant%0d", i), 32'(grants[i]), 32'((i % 2) == 0));
`else
            check_val($sformatf("contend_grant%0d", i), 32'(grants[i]), 32'd1);
`endif
        end
        repeat (4) cycle();

        // Display request raised while the CPU access is in ISSUE
        c0 = n_cpu_rdy;
        d0 = n_disp_rdy;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h040;
        cycle();
        check_val("late_disp_issue", 32'(mem_en), 32'd1);
        disp_req = 1'b1; disp_addr = 12'h050;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (cpu_ready)  cpu_req = 1'b0;
            if (disp_ready) disp_req = 1'b0;
        end
        check_val("late_disp_cpu_pulses",  32'(n_cpu_rdy - c0),  32'd1);
        check_val("late_disp_disp_pulses", 32'(n_disp_rdy - d0), 32'd1);

        // Reset during CAPTURE abandons the access; held req is re-served
        c0 = n_cpu_rdy;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check_val("mid_rst_cpu_ready",  32'(cpu_ready),  32'd0);
        check_val("mid_rst_disp_ready", 32'(disp_ready), 32'd0);
        check_val("mid_rst_mem_en",     32'(mem_en),     32'd0);
        check_val("mid_rst_mem_we",     32'(mem_we),     32'd0);
        check_val("mid_rst_mem_addr",   32'(mem_addr),   32'd0);
        check_val("mid_rst_mem_wdata",  32'(mem_wdata),  32'd0);
        check_val("mid_rst_cpu_rdata",  32'(cpu_rdata),  32'd0);
        check_val("mid_rst_disp_rdata", 32'(disp_rdata), 32'd0);
        check_val("mid_rst_busy",       32'(busy),       32'd0);
        check_val("mid_rst_no_pulse",   32'(n_cpu_rdy - c0), 32'd0);
        reset = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle();
            if (cpu_ready) begin
                got = 1'b1;
                check_val("post_rst_data", 32'(cpu_rdata), 32'hA2);
            end
        end
        if (!got) check_val("post_rst_timeout", 32'd0, 32'd1);
        cpu_req = 1'b0;
        repeat (4) cycle();
        check_val("post_rst_pulses", 32'(n_cpu_rdy - c0), 32'd1);

        // Random traffic from both agents with occasional reset pulses
        c_hold = 1'b0;
        d_hold = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            cycle();
            reset = ($urandom_range(299, 0) == 0);
            if (cpu_ready) c_hold = 1'b1;
            else if (c_hold) begin
                c_hold = 1'b0;
                if ($urandom_range(1, 0) == 1) new_cpu();
                else cpu_req = 1'b0;
            end else if (!cpu_req && $urandom_range(2, 0) == 0) new_cpu();
            if (disp_ready) d_hold = 1'b1;
            else if (d_hold) begin
                d_hold = 1'b0;
                if ($urandom_range(1, 0) == 1) new_disp();
                else disp_req = 1'b0;
            end else if (!disp_req && $urandom_range(2, 0) == 0) new_disp();
        end
        reset = 1'b0;
        cpu_req = 1'b0;
        disp_req = 1'b0;
        repeat (6) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the RAM word-address width (4 KiB CHIP-8 memory).
REQ-002 Parameter DATA_W, default 8, SHALL set the RAM data width.
REQ-003 clk  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU access request, held with addr/we/wdata stable until cpu_ready.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  ADDR_W  CPU address.
REQ-008 cpu_wdata  input  DATA_W  CPU write data.
REQ-009 cpu_ready  output  1  one-cycle completion pulse to CPU.
REQ-010 cpu_rdata  output  DATA_W  CPU read data, valid while cpu_ready=1.
REQ-011 disp_req  input  1  display-scanout read request, held with disp_addr stable until disp_ready.
REQ-012 disp_addr  input  ADDR_W  display read address.
REQ-013 disp_ready  output  1  one-cycle completion pulse to display.
REQ-014 disp_rdata  output  DATA_W  display read data, valid while disp_ready=1.
REQ-015 mem_en  output  1  RAM enable, registered.
REQ-016 mem_we  output  1  RAM write enable, registered.
REQ-017 mem_addr  output  ADDR_W  RAM address, registered.
REQ-018 mem_wdata  output  DATA_W  RAM write data, registered.
REQ-019 mem_rdata  input  DATA_W  synchronous-read RAM output, valid the cycle after the RAM samples mem_en.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, CAPTURE, ACK; transitions IDLE->ISSUE (any req), ISSUE->CAPTURE, CAPTURE->ACK, ACK->IDLE, all unconditional except the first.
REQ-022 In IDLE with any req high, the arbiter SHALL pick one winner (REQ-030/031), register its address (and for CPU, we/wdata) onto mem_*, assert mem_en, store grant owner.
REQ-023 In ISSUE, mem_en/mem_we SHALL be high for exactly this one cycle; both SHALL be 0 in every other state.
REQ-024 On the CAPTURE->ACK edge the arbiter SHALL register mem_rdata into the owner's rdata register and set the owner's ready to 1.
REQ-025 In ACK, exactly the owner's ready SHALL be 1; it SHALL clear on the ACK->IDLE edge.
REQ-026 Latency: request accepted at edge E0 -> ready high between edges E2 and E3; one access per 4 cycles maximum throughput.
REQ-027 req sampled during ACK SHALL be ignored; a requester dropping req at E3 SHALL therefore never be served twice.
REQ-028 CPU writes SHALL complete with cpu_ready after the same latency; cpu_rdata SHALL hold its previous value on writes.
REQ-029 The non-owner's ready and rdata SHALL remain unchanged throughout another requester's transaction.
REQ-030 A request arriving while busy SHALL wait; no request SHALL be dropped while its req remains high.
REQ-031 Both req high in IDLE: winner per Configuration section.

Reset
REQ-032 reset SHALL force IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ready=0, disp_ready=0, cpu_rdata=0, disp_rdata=0, busy=0, last-grant=display.
REQ-033 reset asserted mid-transaction SHALL abandon it without ready; a write already issued may have reached RAM; requester re-presents after reset.

Configuration
REQ-034 Macro MEM_ARB_ROUND_ROBIN_EN defined: on contention the requester not granted last SHALL win; last-grant updates on every grant.
REQ-035 Macro undefined: fixed priority, CPU SHALL always win contention; no last-grant register.

Verification
REQ-036 CPU read addr 0x200 (RAM holds 0xA2) -> mem_en 1 cycle after accept, cpu_ready 3 edges after accept, cpu_rdata=0xA2, disp_ready stays 0.
REQ-037 CPU write 0x300<=0x5C then read 0x300 -> mem_we one cycle, cpu_ready for both, read returns 0x5C.
REQ-038 cpu_req and disp_req both held high 8 transactions -> RR build: grants alternate CPU,disp,... starting CPU; fixed build: 8 CPU grants, disp never.
REQ-039 disp_req raised during CPU ISSUE -> disp served in the next IDLE, exactly one disp_ready.
REQ-040 reset pulsed in CAPTURE -> no ready pulse, outputs at reset values next cycle, held req re-served after reset releases.
REQ-041 Requester holds req through ACK and drops on ready edge -> exactly one ready pulse per request.
